// File: rtl/vend_pkg.sv
// vend_pkg: shared coin/state types and coin arithmetic helpers for the vend path
package vend_pkg;
    typedef enum logic [1:0] {COIN_1, COIN_5, COIN_10, COIN_25} coin_t;
    typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE, S_FAULT} state_t;
    localparam int REM_W = 16;
    function automatic logic [4:0] coin_value(coin_t c);
        return c == COIN_25 ? 5'd25 : c == COIN_10 ? 5'd10 : c == COIN_5 ? 5'd5 : 5'd1;
    endfunction
    function automatic coin_t greedy_coin(logic [REM_W-1:0] rem);
        return rem >= 16'd25 ? COIN_25 : rem >= 16'd10 ? COIN_10 : rem >= 16'd5 ? COIN_5 : COIN_1;
    endfunction
endpackage

// File: rtl/vend_change_engine.sv
// vend_change_engine: hopper handshake and greedy largest-coin selection for payout
module vend_change_engine
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 7
) (
    input  logic                active_i,
    input  logic [CREDIT_W-1:0] credit_i,
    input  logic                ack_i,
    output logic                req_o,
    output logic [1:0]          type_o,
    output logic                take_o,
    output logic [CREDIT_W-1:0] dec_o
);
    coin_t coin;
    assign coin   = greedy_coin(REM_W'(credit_i));
    assign req_o  = active_i;
    assign type_o = active_i ? coin : COIN_1;
    assign take_o = active_i && ack_i;
    assign dec_o  = CREDIT_W'(coin_value(coin));
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: credit accumulation, motor dispense, change payout and motor-timeout fault
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE         = 51,
    parameter int CREDIT_W      = 7,
    parameter int MOTOR_TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_ready,
    input  logic                cancel,
    output logic                motor_en,
    input  logic                motor_done,
    output logic                change_req,
    output logic [1:0]          change_type,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                fault
);
    localparam int CNT_W = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOTOR_TIMEOUT - 1);
    state_t state_q;
    logic [CREDIT_W-1:0] credit_q, sum, dec;
    logic [CNT_W-1:0] cnt_q;
    logic accept, take;
    assign accept     = coin_valid && coin_ready;
    assign sum        = credit_q + (accept ? CREDIT_W'(coin_value(coin_t'(coin_type))) : '0);
    assign coin_ready = state_q == S_IDLE;
    assign motor_en   = state_q == S_VEND;
    assign fault      = state_q == S_FAULT;
    assign credit     = credit_q;
    vend_change_engine #(.CREDIT_W(CREDIT_W)) u_change (
        .active_i(state_q == S_CHANGE),
        .credit_i(credit_q),
        .ack_i   (change_ack),
        .req_o   (change_req),
        .type_o  (change_type),
        .take_o  (take),
        .dec_o   (dec)
    );
    // Main FSM: coin intake, motor run with timeout, payout until credit drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    credit_q <= sum;
                    if (sum >= PRICE_C) begin
                        state_q <= S_VEND;
                        cnt_q   <= '0;
                    end else if (cancel && sum != '0) begin
                        state_q <= S_CHANGE;
                    end
                end
                S_VEND: begin
                    if (motor_done) begin
                        credit_q <= credit_q - PRICE_C;
                        state_q  <= credit_q == PRICE_C ? S_IDLE : S_CHANGE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CHANGE: begin
                    if (take) begin
                        credit_q <= credit_q - dec;
                        if (credit_q == dec) state_q <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
    // Credit never wraps when a coin is added; idle credit stays below PRICE
    assert property (@(posedge clk) disable iff (!rst_n) accept |-> sum >= credit_q);
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed and randomized checks against a payout-queue model
module tb_vend_sequencer;
    localparam int PRICE = 51;
    localparam int CW = 7;
    localparam int TMO = 1000;
    localparam int P_IDLE = 0, P_VEND = 1, P_CHANGE = 2, P_FAULT = 3;
    logic clk = 0, rst_n = 0;
    logic coin_valid = 0, cancel = 0, motor_done = 0, change_ack = 0;
    logic [1:0] coin_type = 0;
    logic coin_ready, motor_en, change_req, fault;
    logic [1:0] change_type;
    logic [CW-1:0] credit;
    int n_checks = 0, n_err = 0;
    bit chk_en = 0;
    int m_phase, m_credit, vcyc;
    int chq[$];
    int vals[4] = '{1, 5, 10, 25};
    int cr2[5] = '{4, 3, 2, 1, 0};
    int ty2[5] = '{0, 0, 0, 0, 0};
    int cr4[6] = '{14, 4, 3, 2, 1, 0};
    int ty4[6] = '{2, 0, 0, 0, 0, 0};

    vend_sequencer #(.PRICE(PRICE), .CREDIT_W(CW), .MOTOR_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_ready(coin_ready), .cancel(cancel), .motor_en(motor_en), .motor_done(motor_done),
        .change_req(change_req), .change_type(change_type), .change_ack(change_ack),
        .credit(credit), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int code(input int v);
        return v == 25 ? 3 : v == 10 ? 2 : v == 5 ? 1 : 0;
    endfunction

    task automatic load_change(input int r);
        chq.delete();
        while (r > 0) begin
            int d;
            d = r >= 25 ? 25 : r >= 10 ? 10 : r >= 5 ? 5 : 1;
            chq.push_back(d);
            r -= d;
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_credit = 0;
        vcyc = 0;
        chq.delete();
    endtask

    task automatic model_step();
        int c;
        case (m_phase)
            P_IDLE: begin
                c = m_credit + (coin_valid ? vals[coin_type] : 0);
                m_credit = c;
                if (c >= PRICE) begin
                    m_phase = P_VEND;
                    vcyc = 0;
                end else if (cancel && c > 0) begin
                    load_change(c);
                    m_phase = P_CHANGE;
                end
            end
            P_VEND: begin
                vcyc++;
                if (motor_done) begin
                    m_credit -= PRICE;
                    if (m_credit > 0) begin
                        load_change(m_credit);
                        m_phase = P_CHANGE;
                    end else m_phase = P_IDLE;
                end else if (vcyc == TMO) m_phase = P_FAULT;
            end
            P_CHANGE: if (change_ack) begin
                m_credit -= chq.pop_front();
                if (chq.size() == 0) m_phase = P_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic tick(input logic cv, input logic [1:0] ct, input logic cn, input logic md, input logic ack);
        coin_valid = cv; coin_type = ct; cancel = cn; motor_done = md; change_ack = ack;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        coin_valid = 0; cancel = 0; motor_done = 0; change_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("cmp_coin_ready", coin_ready, m_phase == P_IDLE);
        chk("cmp_motor_en", motor_en, m_phase == P_VEND);
        chk("cmp_change_req", change_req, m_phase == P_CHANGE);
        chk("cmp_change_type", change_type, m_phase == P_CHANGE ? code(chq[0]) : 0);
        chk("cmp_credit", credit, m_credit);
        chk("cmp_fault", fault, m_phase == P_FAULT);
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1 chk_en = 1;
        chk("rst_coin_ready", coin_ready, 1);
        chk("rst_credit", credit, 0);
        chk("rst_motor_en", motor_en, 0);
        chk("rst_change_req", change_req, 0);
        chk("rst_change_type", change_type, 0);
        chk("rst_fault", fault, 0);
        @(posedge clk);
        #1 rst_n = 1;
        tick(1, 3, 0, 0, 0);
        tick(1, 3, 0, 0, 0);
        chk("t1_credit50", credit, 50);
        chk("t1_no_motor", motor_en, 0);
        tick(1, 0, 0, 0, 0);
        chk("t1_motor_on", motor_en, 1);
        chk("t1_credit51", credit, 51);
        tick(1, 3, 0, 0, 0);
        chk("t1_coin_ignored", credit, 51);
        tick(0, 0, 0, 1, 0);
        chk("t1_motor_off", motor_en, 0);
        chk("t1_no_change", change_req, 0);
        chk("t1_idle_credit", credit, 0);
        chk("t1_idle_ready", coin_ready, 1);
        tick(1, 3, 0, 0, 0);
        tick(1, 3, 0, 0, 0);
        tick(1, 2, 0, 0, 0);
        chk("t2_credit60", credit, 60);
        tick(0, 0, 0, 1, 0);
        chk("t2_credit9", credit, 9);
        chk("t2_req", change_req, 1);
        chk("t2_type5", change_type, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 1);
            chk("t2_credit", credit, cr2[i]);
            chk("t2_type", change_type, ty2[i]);
            chk("t2_req_seq", change_req, cr2[i] != 0);
        end
        tick(1, 2, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        chk("t3_credit15", credit, 15);
        chk("t3_type10", change_type, 2);
        chk("t3_no_motor", motor_en, 0);
        tick(0, 0, 0, 0, 1);
        chk("t3_credit5", credit, 5);
        chk("t3_type5", change_type, 1);
        tick(0, 0, 0, 0, 1);
        chk("t3_credit0", credit, 0);
        chk("t3_req_off", change_req, 0);
        tick(1, 3, 0, 0, 0);
        tick(1, 3, 0, 0, 0);
        tick(1, 3, 1, 0, 0);
        chk("t4_credit75", credit, 75);
        chk("t4_motor_on", motor_en, 1);
        chk("t4_no_refund", change_req, 0);
        tick(0, 0, 0, 1, 0);
        chk("t4_credit24", credit, 24);
        chk("t4_type10", change_type, 2);
        chk("t4_model_q", chq.size(), 6);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 0, 1);
            chk("t4_credit", credit, cr4[i]);
            chk("t4_type", change_type, ty4[i]);
        end
        tick(1, 3, 0, 0, 0);
        tick(1, 3, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) tick(0, 0, 0, 0, 0);
        chk("t5_motor_last", motor_en, 1);
        chk("t5_no_fault_yet", fault, 0);
        tick(0, 0, 0, 0, 0);
        chk("t5_fault", fault, 1);
        chk("t5_motor_off", motor_en, 0);
        chk("t5_not_ready", coin_ready, 0);
        chk("t5_credit_held", credit, 51);
        tick(1, 3, 1, 1, 1);
        tick(0, 0, 0, 1, 0);
        chk("t5_fault_sticky", fault, 1);
        chk("t5_credit_sticky", credit, 51);
        do_reset();
        chk("t5_fault_cleared", fault, 0);
        tick(1, 3, 0, 0, 0);
        tick(1, 3, 0, 0, 0);
        tick(1, 2, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        chk("t6_credit4", credit, 4);
        chk("t6_req", change_req, 1);
        rst_n = 0;
        model_reset();
        #1;
        chk("t6_async_req", change_req, 0);
        chk("t6_async_credit", credit, 0);
        chk("t6_async_ready", coin_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        chk("t6_ready_after", coin_ready, 1);
        for (int i = 0; i < 4000; i++) begin
            if (m_phase == P_FAULT || $urandom_range(0, 299) == 0) do_reset();
            else tick($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
        end
        @(posedge clk);
        #1 chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
